// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: request-side controller for one 1R1W byte-masked SRAM macro.
//
// Requests arrive on a valid/ready port. Writes go straight to the macro's W0
// pins in the fire cycle and produce no response. Reads drive R0 in the fire
// cycle. The macro returns data one cycle later, and that data is pushed into a
// small response FIFO. Reads are admitted only while a FIFO slot is reserved
// for them, so stalling the response port never drops data.
//
// Ports:
//   clock, reset_n        clock (also the macro clock), async active-low reset
//   req_valid/ready       request handshake
//   req_write             1 = write, 0 = read
//   req_addr/data/mask    word address, write data, byte enables
//   rsp_valid/ready       response handshake
//   rsp_data              FIFO head, read data
//   mem_W0_*              macro write port (en, addr, data, mask)
//   mem_R0_*              macro read port (en, addr, data returned next cycle)
//   busy                  a read is in flight or responses are buffered
module sram_port_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = DATA_W / 8,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [MASK_W-1:0] req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic              busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RSP_DEPTH);

  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  fifo_count;
  logic              rd_pending;

  logic              fire;
  logic              enq;
  logic              deq;
  logic [CNT_W:0]    credits_used;

  // A slot is spoken for as soon as the read is in flight, so the credit check
  // counts the pending read together with buffered entries. Only registered
  // state feeds req_ready, which keeps it free of combinational paths from the
  // request or response handshakes.
  always_comb begin
    credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
    req_ready    = reset_n & (credits_used < DEPTH_EXT);
    fire         = req_valid & req_ready;
  end

  always_comb begin
    mem_W0_en   = fire & req_write & (|req_mask);
    mem_W0_addr = req_addr;
    mem_W0_data = req_data;
    mem_W0_mask = req_mask;
    mem_R0_en   = fire & ~req_write;
    mem_R0_addr = req_addr;
  end

  always_comb begin
    enq       = rd_pending;
    rsp_valid = (fifo_count != '0);
    deq       = rsp_valid & rsp_ready;
    rsp_data  = fifo_mem[head];
    busy      = rd_pending | rsp_valid;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      rd_pending <= mem_R0_en;
      if (enq) tail <= ptr_inc(tail);
      if (deq) head <= ptr_inc(head);
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (enq) fifo_mem[tail] <= mem_R0_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(enq && fifo_count == FULL_CNT));

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        mem_W0_en;
  logic [9:0]  mem_W0_addr;
  logic [31:0] mem_W0_data;
  logic [3:0]  mem_W0_mask;
  logic        mem_R0_en;
  logic [9:0]  mem_R0_addr;
  logic [31:0] mem_R0_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  sram_port_ctrl #(.ADDR_W(10), .DATA_W(32), .MASK_W(4), .RSP_DEPTH(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
    .mem_W0_mask(mem_W0_mask), .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr),
    .mem_R0_data(mem_R0_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // SRAM macro model: synchronous masked write, registered read data.
  logic [31:0] sram [1024];
  logic [31:0] r0_q;
  assign mem_R0_data = r0_q;
  always @(posedge clock) begin
    if (mem_R0_en) r0_q <= sram[mem_R0_addr];
    if (mem_W0_en) sram[mem_W0_addr] = merge(sram[mem_W0_addr], mem_W0_data, mem_W0_mask);
  end

  // Reference model: architectural memory image, expected-response queue and
  // the number of reads accepted but not yet consumed.
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q [$];
  int          outstanding = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic        fire_m;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    end
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!reset_n) begin
      check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_w0_en", {31'b0, mem_W0_en}, 32'd0);
      check_eq("rst_r0_en", {31'b0, mem_R0_en}, 32'd0);
      exp_q.delete();
      outstanding = 0;
      hold_prev   = 1'b0;
    end else begin
      check_eq("req_ready_credit", {31'b0, req_ready}, {31'b0, outstanding < 3});
      fire_m = req_valid && req_ready;
      check_eq("w0_en", {31'b0, mem_W0_en}, {31'b0, fire_m && req_write && (req_mask != 4'd0)});
      if (mem_W0_en) begin
        check_eq("w0_addr", {22'b0, mem_W0_addr}, {22'b0, req_addr});
        check_eq("w0_data", mem_W0_data, req_data);
        check_eq("w0_mask", {28'b0, mem_W0_mask}, {28'b0, req_mask});
      end
      check_eq("r0_en", {31'b0, mem_R0_en}, {31'b0, fire_m && !req_write});
      if (mem_R0_en) check_eq("r0_addr", {22'b0, mem_R0_addr}, {22'b0, req_addr});
      check_eq("busy", {31'b0, busy}, {31'b0, outstanding != 0});
      if (hold_prev) begin
        check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("hold_data", rsp_data, hold_data);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stray_rsp: got response 0x%08h, expected none", rsp_data);
        end else if (rsp_ready) begin
          check_eq("rsp_order", rsp_data, exp_q.pop_front());
          outstanding--;
        end
      end
      if (fire_m && req_write)
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_mask);
      if (fire_m && !req_write) begin
        exp_q.push_back(ref_mem[req_addr]);
        outstanding++;
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
    end
  end

  task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    int unsigned n;
    logic acc;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clock);
      acc = req_ready;
      if (!acc) begin
        n++;
        if (n > 100) begin
          timeout_fail("req_accept");
          acc = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) timeout_fail("wait_idle");
    @(posedge clock);
    #1;
  endtask

  // Read issued into an empty FIFO: no response in t+1, response in t+2.
  task automatic read_latency(input string name, input logic [9:0] a, input logic [31:0] exp);
    do_req(1'b0, a, 32'd0, 4'd0);
    @(negedge clock);
    check_eq({name, "_t1_valid"}, {31'b0, rsp_valid}, 32'd0);
    @(negedge clock);
    check_eq({name, "_t2_valid"}, {31'b0, rsp_valid}, 32'd1);
    check_eq({name, "_t2_data"}, rsp_data, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int fires;
    logic rdy;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_mask  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Write then read the same address on the next cycle.
    do_req(1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    read_latency("raw", 10'h005, 32'hDEADBEEF);
    wait_idle();

    // Byte-mask merge, then an all-zero-mask write that must not change it.
    do_req(1'b1, 10'h3FF, 32'h11223344, 4'hF);
    do_req(1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5);
    read_latency("merge", 10'h3FF, 32'h11BB33DD);
    do_req(1'b1, 10'h3FF, 32'hFFFFFFFF, 4'h0);
    read_latency("mask0", 10'h3FF, 32'h11BB33DD);
    wait_idle();

    // Streaming reads: one per cycle, responses start two cycles later.
    for (int i = 0; i < 18; i++) begin
      req_valid = (i < 16);
      req_write = 1'b0;
      req_addr  = 10'(i);
      @(negedge clock);
      if (i < 16) check_eq("stream_ready", {31'b0, req_ready}, 32'd1);
      if (i < 2) check_eq("stream_early", {31'b0, rsp_valid}, 32'd0);
      else begin
        check_eq("stream_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("stream_data", rsp_data, ref_mem[i-2]);
      end
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    wait_idle();

    // Backpressure: three reads fit, the fourth is held off.
    rsp_ready = 1'b0;
    fires     = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'd100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      rdy = req_ready;
      @(posedge clock);
      #1;
      if (rdy) fires++;
      req_addr = 10'(100 + fires);
    end
    req_valid = 1'b0;
    @(negedge clock);
    check_eq("bp_fires", 32'(fires), 32'd3);
    check_eq("bp_ready_low", {31'b0, req_ready}, 32'd0);
    check_eq("bp_head", rsp_data, ref_mem[100]);
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("bp_drain_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_drain_data", rsp_data, ref_mem[100+i]);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check_eq("bp_empty", {31'b0, rsp_valid}, 32'd0);
    check_eq("bp_ready_back", {31'b0, req_ready}, 32'd1);
    wait_idle();

    // Enqueue and dequeue in the same cycle with two entries buffered.
    rsp_ready = 1'b0;
    do_req(1'b0, 10'd200, 32'd0, 4'd0);
    do_req(1'b0, 10'd201, 32'd0, 4'd0);
    do_req(1'b0, 10'd202, 32'd0, 4'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) check_eq("sim_ready_full", {31'b0, req_ready}, 32'd0);
      if (i == 1) check_eq("sim_ready_back", {31'b0, req_ready}, 32'd1);
      if (i < 3) begin
        check_eq("sim_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("sim_data", rsp_data, ref_mem[200+i]);
      end else check_eq("sim_empty", {31'b0, rsp_valid}, 32'd0);
      @(posedge clock);
      #1;
    end
    wait_idle();

    // Reset with one read pending and two responses buffered.
    rsp_ready = 1'b0;
    do_req(1'b0, 10'd300, 32'd0, 4'd0);
    do_req(1'b0, 10'd301, 32'd0, 4'd0);
    do_req(1'b0, 10'd302, 32'd0, 4'd0);
    #1;
    check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("async_rst_ready", {31'b0, req_ready}, 32'd0);
    check_eq("async_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("post_rst_quiet", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clock);
    #1;
    do_req(1'b1, 10'h123, 32'hCAFEF00D, 4'hF);
    read_latency("post_rst", 10'h123, 32'hCAFEF00D);
    wait_idle();

    // Randomised traffic over a small address window with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) != 0;
      req_addr  = 10'($urandom_range(0, 31));
      req_data  = $urandom;
      req_mask  = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check_eq("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Request-side controller that owns one 1R1W byte-masked SRAM macro: 1024x32, synchronous write, registered read address, read data valid the cycle after R0_en.
- Accepts read/write requests on a valid/ready port, drives the macro's W0/R0 pins, and returns read data on a valid/ready response port.
- Captures read data into a response FIFO and uses credit-based flow control, so response backpressure never loses data.
- Sits between an LSU/cache pipeline stage and the SRAM macro in the same clock domain.

Parameters:
ADDR_W, 10, SRAM word-address width (depth 2^ADDR_W)
DATA_W, 32, data width; multiple of 8
MASK_W, DATA_W/8, byte-enable width
RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 or more is required for one read per cycle

Ports:
clock  in  1  sole clock; also clocks the SRAM macro's W0_clk and R0_clk
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready ("fire")
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_data  in  DATA_W  write data
req_mask  in  MASK_W  byte enables, bit i covers bits [8i+7:8i]
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_W  read data, FIFO head
mem_W0_en  out  1  SRAM write enable
mem_W0_addr  out  ADDR_W  SRAM write address
mem_W0_data  out  DATA_W  SRAM write data
mem_W0_mask  out  MASK_W  SRAM byte mask
mem_R0_en  out  1  SRAM read enable
mem_R0_addr  out  ADDR_W  SRAM read address
mem_R0_data  in  DATA_W  SRAM read data, valid in the cycle after mem_R0_en
busy  out  1  rd_pending | FIFO non-empty

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied, rd_pending=0, rsp_valid=0, busy=0.
  - req_ready forced 0, so mem_W0_en=0 and mem_R0_en=0.
  - rsp_data value is don't-care while rsp_valid=0.
- Credit rule: req_ready = reset_n & ((fifo_count + rd_pending) < RSP_DEPTH).
  - Uses registered state only; does not depend on req_valid, req_write or rsp_ready.
  - Applies to writes as well as reads.
- Write fire (same cycle, combinational):
  - mem_W0_en = fire & req_write & (|req_mask).
  - mem_W0_addr/data/mask = req_addr/data/mask.
  - An all-zero mask is accepted and completes with no SRAM write.
  - Writes produce no response.
- Read fire at cycle t:
  - mem_R0_en = fire & ~req_write, mem_R0_addr = req_addr in cycle t.
  - rd_pending=1 during cycle t+1; mem_R0_data is sampled in t+1 and enqueued at the end of t+1.
  - rsp_valid rises in t+2. Read-to-response latency is exactly 2 cycles when the FIFO is empty.
- Idle outputs: when not firing, mem_W0_en=0 and mem_R0_en=0. Address/data outputs may follow req_* (don't-care).
- Read-after-write: a write at t followed by a read of the same address at t+1 returns the new data. No forwarding is needed because the macro updates at the t edge.
- FIFO:
  - Circular, RSP_DEPTH entries; wrap pointers modulo RSP_DEPTH.
  - Dequeue on rsp_valid & rsp_ready; rsp_data = head entry, stable while rsp_valid & ~rsp_ready.
  - Simultaneous enqueue and dequeue: count unchanged. Enqueue into an empty FIFO is visible next cycle, with no same-cycle bypass.
  - Overflow is impossible by construction. Assertion: enqueue with fifo_count==RSP_DEPTH is an error.
- Ordering: responses return in read-request order.
- Reset mid-operation: in-flight read and buffered responses are discarded. No response is emitted after reset deassertion until a new read fires.

Test Plan:
- Write addr 0x005 data 0xDEADBEEF mask 0xF, then read 0x005 next cycle -> mem_W0_en pulses 1 cycle; rsp_valid 2 cycles after the read fire; rsp_data=0xDEADBEEF.
- Mask merge: write 0x11223344 mask 0xF, then 0xAABBCCDD mask 0x5 to 0x3FF, then read 0x3FF -> rsp_data=0x11BB33DD. A mask 0x0 write leaves it 0x11BB33DD and mem_W0_en stays 0.
- Streaming reads of addrs 0..15 with rsp_ready=1 and RSP_DEPTH=3 -> req_ready constantly 1; 16 responses in order, one per cycle, starting 2 cycles after the first fire.
- Backpressure: rsp_ready=0 while issuing reads -> exactly 3 fires, then req_ready=0. rsp_data holds the first value. Raise rsp_ready -> 3 responses drain in order, then req_ready=1.
- Simultaneous enqueue and dequeue with fifo_count=2 -> count stays 2; no drop or duplicate; req_ready per credit formula.
- Assert reset_n low with 1 pending read and 2 buffered responses -> rsp_valid=0, req_ready=0, busy=0 immediately. After release, no stray response; the next read returns correct data with 2-cycle latency.
